// File: rtl/onn_settle_monitor_if.sv
// Interface bundling the control, phase and result signals of onn_settle_monitor.
// master: phase bank / host side, slave: the monitor itself.
interface onn_settle_monitor_if #(
  parameter int unsigned N     = 15,
  parameter int unsigned PHI_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic                 start;
  logic                 full_tick;
  logic [N-1:0]         state_changed;
  logic [0:N*PHI_W-1]   phi_in;
  logic                 busy;
  logic                 done;
  logic                 converged;
  logic                 timeout;
  logic [CNT_W-1:0]     period_count;
  logic [0:N*PHI_W-1]   phi_snapshot;
  logic [CNT_W-1:0]     last_flips;

  modport master (
    output start, full_tick, state_changed, phi_in,
    input  busy, done, converged, timeout, period_count, phi_snapshot, last_flips
  );

  modport slave (
    input  start, full_tick, state_changed, phi_in,
    output busy, done, converged, timeout, period_count, phi_snapshot, last_flips
  );
endinterface

// File: rtl/onn_settle_monitor.sv
// Convergence monitor for the oscillatory neuron phase bank.
// Counts oscillation periods, declares convergence after STABLE_PERIODS
// change-free periods or timeout after MAX_PERIODS, and latches a phase
// snapshot at termination.
// Optional per-period flip counter: define ONN_SETTLE_FLIP_COUNT_EN.
module onn_settle_monitor #(
  parameter int unsigned N              = 15,
  parameter int unsigned PHI_W          = 4,
  parameter int unsigned STABLE_PERIODS = 4,
  parameter int unsigned MAX_PERIODS    = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onn_settle_monitor_if.slave  bus
);

  localparam int unsigned PHV_W = N * PHI_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               converged_q, converged_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   stable_q, stable_d;
  logic               chg_acc_q, chg_acc_d;
  logic [0:PHV_W-1]   snap_q, snap_d;

  logic               chg_any;
  logic [CNT_W-1:0]   stable_inc;
  logic [CNT_W-1:0]   period_inc;
  logic               hit_conv;
  logic               hit_tmo;

`ifdef ONN_SETTLE_FLIP_COUNT_EN
  logic [N-1:0]       flip_vec_q, flip_vec_d;
  logic [CNT_W-1:0]   last_flips_q, last_flips_d;
  logic [N-1:0]       flip_now;

  // Count of set bits in a neuron flag vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  // Neurons that changed so far in the current period, including this cycle.
  always_comb begin
    flip_now = flip_vec_q | bus.state_changed;
  end
`endif

  // Period-end decision terms: tick-cycle flags count toward the ending period.
  always_comb begin
    chg_any    = chg_acc_q | (|bus.state_changed);
    stable_inc = stable_q + CNT_W'(1);
    period_inc = period_q + CNT_W'(1);
    hit_conv   = !chg_any && (stable_inc == CNT_W'(STABLE_PERIODS));
    hit_tmo    = !hit_conv && (period_inc == CNT_W'(MAX_PERIODS));
  end

  // Next-state and next-register values.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    converged_d = converged_q;
    timeout_d   = timeout_q;
    period_d    = period_q;
    stable_d    = stable_q;
    chg_acc_d   = chg_acc_q;
    snap_d      = snap_q;
`ifdef ONN_SETTLE_FLIP_COUNT_EN
    flip_vec_d   = flip_vec_q;
    last_flips_d = last_flips_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        // Fresh run: a full_tick coincident with start is not counted.
        if (bus.start) begin
          state_d     = RUN;
          busy_d      = 1'b1;
          converged_d = 1'b0;
          timeout_d   = 1'b0;
          period_d    = '0;
          stable_d    = '0;
          chg_acc_d   = 1'b0;
`ifdef ONN_SETTLE_FLIP_COUNT_EN
          flip_vec_d  = '0;
`endif
        end
      end

      RUN: begin
        if (bus.full_tick) begin
          chg_acc_d = 1'b0;
          period_d  = period_inc;
          stable_d  = chg_any ? '0 : stable_inc;
`ifdef ONN_SETTLE_FLIP_COUNT_EN
          flip_vec_d   = '0;
          last_flips_d = popcount(flip_now);
`endif
          if (hit_conv || hit_tmo) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            converged_d = hit_conv;
            timeout_d   = hit_tmo;
            snap_d      = bus.phi_in;
          end
        end else begin
          chg_acc_d = chg_any;
`ifdef ONN_SETTLE_FLIP_COUNT_EN
          flip_vec_d = flip_now;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      converged_q <= 1'b0;
      timeout_q   <= 1'b0;
      period_q    <= '0;
      stable_q    <= '0;
      chg_acc_q   <= 1'b0;
      snap_q      <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      converged_q <= converged_d;
      timeout_q   <= timeout_d;
      period_q    <= period_d;
      stable_q    <= stable_d;
      chg_acc_q   <= chg_acc_d;
      snap_q      <= snap_d;
    end
  end

`ifdef ONN_SETTLE_FLIP_COUNT_EN
  // Flip accumulator and per-period flip count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_vec_q   <= '0;
      last_flips_q <= '0;
    end else begin
      flip_vec_q   <= flip_vec_d;
      last_flips_q <= last_flips_d;
    end
  end

  assign bus.last_flips = last_flips_q;
`else
  assign bus.last_flips = '0;
`endif

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.converged    = converged_q;
  assign bus.timeout      = timeout_q;
  assign bus.period_count = period_q;
  assign bus.phi_snapshot = snap_q;

endmodule
